spi_slave_rx: RTL and testbench

SPI receive stage that sits directly downstream of the team's 12-bit SPI master transmitter. It takes the master's `sclk`/`mosi`/`cs` pins as asynchronous inputs and oversamples them on the system clock. It deframes each LSB-first word and presents it on a valid/ready output port to the consuming logic.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_rx.sv | 135 +++++++++++++
 tb/tb_spi_slave_rx.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive path: FSM state encoding,
// default frame width and the reset values of the pin synchronisers.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT
  } spi_rx_state_t;

  localparam int SPI_DATA_W = 12;

  localparam logic SYNC_RST_SCLK = 1'b0;
  localparam logic SYNC_RST_MOSI = 1'b0;
  localparam logic SYNC_RST_CS   = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, followed by a delay flop
// that turns the synchronised level into single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s_p0, s_p1, d_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_p0 <= RST_VAL;
      s_p1 <= RST_VAL;
      d_p2 <= RST_VAL;
    end else begin
      s_p0 <= pin;
      s_p1 <= s_p0;
      d_p2 <= s_p1;
    end
  end

  assign q    = s_p1;
  assign rise = s_p1 & ~d_p2;
  assign fall = ~s_p1 & d_p2;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive stage: oversamples sclk/mosi/cs, deframes LSB-first words and
// offers them on a valid/ready port. SPI_RX_ERR_EN adds the frame_err pulse.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready
`ifdef SPI_RX_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 2);

  logic sclk_q, sclk_rise, sclk_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic cs_q, cs_rise, cs_fall;

  spi_sync_edge #(.RST_VAL(SYNC_RST_SCLK)) u_sync_sclk (
    .clk(clk), .rst(rst), .pin(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.RST_VAL(SYNC_RST_MOSI)) u_sync_mosi (
    .clk(clk), .rst(rst), .pin(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );
  spi_sync_edge #(.RST_VAL(SYNC_RST_CS)) u_sync_cs (
    .clk(clk), .rst(rst), .pin(cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_q, sclk_rise, mosi_rise, mosi_fall};

  spi_rx_state_t     state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [1:0]        settle;
  logic              armed;
  logic              eval, good, load;

  // A cs fall is only trusted once the synchroniser has flushed its reset
  // value and the pin has actually been observed high.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else begin
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && cs_q) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    eval      = 1'b0;
    good      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall && armed) state_nxt = ST_LEAD;
      end
      ST_LEAD: begin
        if (cs_rise) begin
          state_nxt = ST_IDLE;
          eval      = 1'b1;
        end else if (sclk_fall) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = '0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_nxt = ST_IDLE;
          eval      = 1'b1;
          good      = (cnt == CNT_W'(DATA_W));
        end else if (sclk_fall) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt == CNT_W'(i)) shreg_nxt[i] = mosi_q;
          end
          // Saturating at DATA_W+1 keeps overlong frames distinguishable.
          if (cnt != CNT_W'(DATA_W + 1)) cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A held word blocks the load unless it is being consumed this same cycle.
  assign load = good && (!dout_valid || dout_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (load) begin
        dout       <= shreg;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_RX_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= eval && !load;
  end
`else
  logic unused_eval;
  assign unused_eval = eval;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: an SPI master model drives LSB-first
// frames and expected words are queued, then matched on each handshake.
module tb_spi_slave_rx;

  localparam int DATA_W = 12;
  localparam int H      = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              sclk;
  logic              mosi;
  logic              cs;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
`ifdef SPI_RX_ERR_EN
  logic              frame_err;
`endif

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
    .sclk(sclk),
    .mosi(mosi),
    .cs(cs),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready)
`ifdef SPI_RX_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each handshake must consume the oldest expected word.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("dout_word", 32'(dout), 32'(exp_q.pop_front()));
    end
`ifdef SPI_RX_ERR_EN
    if (!rst && frame_err) err_cnt++;
`endif
  end

  // nbits data falls follow the lead-in fall; rst_after pulses rst after that fall index.
  task automatic send(input logic [DATA_W-1:0] w, input int nbits, input int rst_after);
    cs = 1'b0;
    wait_clks(H);
    for (int k = 0; k <= nbits; k++) begin
      sclk = 1'b1;
      if (k > 0) mosi = (k - 1 < DATA_W) ? w[k-1] : 1'b0;
      wait_clks(H);
      sclk = 1'b0;
      wait_clks(H);
      if (k == rst_after) begin
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
      end
    end
    cs = 1'b1;
    wait_clks(H);
  endtask

  task automatic check_err(input string tag, input int exp);
`ifdef SPI_RX_ERR_EN
    check(tag, 32'(err_cnt), 32'(exp));
`endif
  endtask

  initial begin
    rst        = 1'b1;
    sclk       = 1'b0;
    mosi       = 1'b0;
    cs         = 1'b1;
    dout_ready = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(1);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
`ifdef SPI_RX_ERR_EN
    check("rst_frame_err", 32'(frame_err), 32'd0);
`endif
    wait_clks(5);

    // single frame
    exp_q.push_back(12'hA5C);
    send(12'hA5C, DATA_W, -1);
    wait_clks(10);
    check("t1_pending", 32'(exp_q.size()), 32'd0);
    check_err("t1_err", 0);

    // back-to-back frames
    exp_q.push_back(12'hFFF);
    send(12'hFFF, DATA_W, -1);
    exp_q.push_back(12'h001);
    send(12'h001, DATA_W, -1);
    wait_clks(10);
    check("t2_pending", 32'(exp_q.size()), 32'd0);
    check_err("t2_err", 0);

    // unconsumed word blocks a second frame
    dout_ready = 1'b0;
    send(12'h123, DATA_W, -1);
    send(12'h456, DATA_W, -1);
    wait_clks(10);
    check("t3_valid_held", 32'(dout_valid), 32'd1);
    check("t3_dout_held", 32'(dout), 32'h123);
    check_err("t3_err", 1);
    exp_q.push_back(12'h123);
    dout_ready = 1'b1;
    wait_clks(5);
    check("t3_valid_clear", 32'(dout_valid), 32'd0);
    check("t3_pending", 32'(exp_q.size()), 32'd0);

    // short frame then a good one
    send(12'h01F, 5, -1);
    wait_clks(10);
    check("t4_short_valid", 32'(dout_valid), 32'd0);
    check_err("t4_short_err", 2);
    exp_q.push_back(12'h0F0);
    send(12'h0F0, DATA_W, -1);
    wait_clks(10);
    check("t4_pending", 32'(exp_q.size()), 32'd0);
    check("t4_dout", 32'(dout), 32'h0F0);

    // overlong frame
    send(12'h7E7, 14, -1);
    wait_clks(10);
    check("t5_long_valid", 32'(dout_valid), 32'd0);
    check_err("t5_long_err", 3);

    // reset after bit 6 with cs still low
    send(12'hABC, DATA_W, 7);
    wait_clks(10);
    check("t6_rst_valid", 32'(dout_valid), 32'd0);
    check("t6_rst_dout", 32'(dout), 32'd0);
    check_err("t6_rst_err", 3);
    exp_q.push_back(12'h321);
    send(12'h321, DATA_W, -1);
    wait_clks(10);
    check("t6_pending", 32'(exp_q.size()), 32'd0);
    check("t6_dout", 32'(dout), 32'h321);
    check_err("t6_final_err", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
